// File: rtl/traffic_phase_scheduler.sv
// Demand-driven round-robin phase sequencer for the four-approach junction.
// Optional pedestrian walk phase is enabled by defining TPS_PED_CROSSING_EN.
//
// state    | meaning
// ALL_RED  | clearance; grants the next pending approach on its last cycle
// GREEN    | granted approach green, min/max green enforced
// YELLOW   | granted approach yellow, grant held
// PED_WALK | all red, walk lamp on (TPS_PED_CROSSING_EN only)
module traffic_phase_scheduler #(
   parameter int MIN_GREEN = 20,
   parameter int MAX_GREEN = 60,
   parameter int YELLOW_T  = 6,
   parameter int ALLRED_T  = 2,
   parameter int PED_T     = 15,
   parameter int CNT_W     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
`ifdef TPS_PED_CROSSING_EN
   input  logic       ped_req,
   output logic       walk,
`endif
   output logic [2:0] light_m1,
   output logic [2:0] light_m2,
   output logic [2:0] light_mT,
   output logic [2:0] light_s,
   output logic [3:0] grant,
   output logic       phase_start
);

   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;

   localparam logic [CNT_W-1:0] T_AR   = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] T_Y    = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] T_MING = CNT_W'(MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] T_MAXG = CNT_W'(MAX_GREEN - 1);
`ifdef TPS_PED_CROSSING_EN
   localparam logic [CNT_W-1:0] T_P    = CNT_W'(PED_T - 1);
`endif

   localparam int LONGEST_A = (MAX_GREEN > YELLOW_T) ? MAX_GREEN : YELLOW_T;
   localparam int LONGEST_B = (ALLRED_T > PED_T) ? ALLRED_T : PED_T;
   localparam int LONGEST   = (LONGEST_A > LONGEST_B) ? LONGEST_A : LONGEST_B;

   if ((2 ** CNT_W) <= LONGEST) begin : g_cnt_w_check
      $error("CNT_W too narrow for the longest phase");
   end

   typedef enum logic [1:0] {
      ALL_RED  = 2'd0,
      GREEN    = 2'd1,
      YELLOW   = 2'd2
`ifdef TPS_PED_CROSSING_EN
      , PED_WALK = 2'd3
`endif
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] timer;
   logic [3:0]       pending;
   logic [1:0]       rr_ptr;
   logic [3:0]       green_mask;
   logic [3:0]       elig;
   logic [1:0]       sel_idx;
   logic [3:0]       sel_oh;
   logic             sel_any;
   logic             cur_req;
   logic             other;
`ifdef TPS_PED_CROSSING_EN
   logic             ped_pending;
`endif

   // Packs the four lamps as {s, mT, m2, m1}: selected approaches get col, the rest red.
   function automatic logic [11:0] lamps(input logic [3:0] oh, input logic [2:0] col);
      logic [11:0] l;
      for (int i = 0; i < 4; i++) begin
         l[i*3 +: 3] = oh[i] ? col : LAMP_R;
      end
      return l;
   endfunction

   always_comb begin
      green_mask = (state == GREEN) ? grant : 4'b0000;
      elig       = pending | req;
      sel_idx    = rr_ptr;
      sel_any    = 1'b0;
      // Walk downwards so the nearest index after rr_ptr is written last and wins.
      for (int k = 4; k >= 1; k--) begin
         if (elig[rr_ptr + 2'(k)]) begin
            sel_idx = rr_ptr + 2'(k);
            sel_any = 1'b1;
         end
      end
      sel_oh  = 4'b0001 << sel_idx;
      cur_req = |(req & grant);
      other   = |(pending & ~grant);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ALL_RED;
         timer       <= '0;
         pending     <= '0;
         rr_ptr      <= 2'd3;
         grant       <= '0;
         phase_start <= 1'b0;
         {light_s, light_mT, light_m2, light_m1} <= lamps(4'b0000, LAMP_R);
`ifdef TPS_PED_CROSSING_EN
         ped_pending <= 1'b0;
         walk        <= 1'b0;
`endif
      end else begin
         phase_start <= 1'b0;
         pending     <= pending | (req & ~green_mask);
`ifdef TPS_PED_CROSSING_EN
         if (state != PED_WALK) ped_pending <= ped_pending | ped_req;
`endif
         case (state)
            ALL_RED: begin
               if (timer < T_AR) timer <= timer + 1'b1;
`ifdef TPS_PED_CROSSING_EN
               else if (ped_pending || ped_req) begin
                  state <= PED_WALK;
                  timer <= '0;
                  walk  <= 1'b1;
               end
`endif
               else if (sel_any) begin
                  state       <= GREEN;
                  timer       <= '0;
                  grant       <= sel_oh;
                  rr_ptr      <= sel_idx;
                  pending     <= elig & ~sel_oh;
                  phase_start <= 1'b1;
                  {light_s, light_mT, light_m2, light_m1} <= lamps(sel_oh, LAMP_G);
               end
            end
            GREEN: begin
               if (timer < T_MAXG) timer <= timer + 1'b1;
               if (other && ((timer >= T_MING && !cur_req) || timer >= T_MAXG)) begin
                  state <= YELLOW;
                  timer <= '0;
                  {light_s, light_mT, light_m2, light_m1} <= lamps(grant, LAMP_Y);
               end
            end
            YELLOW: begin
               if (timer >= T_Y) begin
                  state <= ALL_RED;
                  timer <= '0;
                  grant <= '0;
                  {light_s, light_mT, light_m2, light_m1} <= lamps(4'b0000, LAMP_R);
               end else begin
                  timer <= timer + 1'b1;
               end
            end
`ifdef TPS_PED_CROSSING_EN
            PED_WALK: begin
               if (timer >= T_P) begin
                  state       <= ALL_RED;
                  timer       <= '0;
                  walk        <= 1'b0;
                  ped_pending <= 1'b0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
`endif
            default: state <= ALL_RED;
         endcase
      end
   end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Vector-table bench for traffic_phase_scheduler with a small expected-result queue.
module tb_traffic_phase_scheduler;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;

   // Lamp words are {s, mT, m2, m1}.
   localparam logic [11:0] ALLR = {R, R, R, R};
   localparam logic [11:0] M1G  = {R, R, R, G};
   localparam logic [11:0] M1Y  = {R, R, R, Y};
   localparam logic [11:0] M2G  = {R, R, G, R};
   localparam logic [11:0] M2Y  = {R, R, Y, R};
   localparam logic [11:0] TG   = {R, G, R, R};
   localparam logic [11:0] TY   = {R, Y, R, R};
   localparam logic [11:0] SG   = {G, R, R, R};
   localparam logic [11:0] SY   = {Y, R, R, R};

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [11:0] lights;
      logic [3:0]  grant;
      logic        ps;
   } vec_t;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] req   = 4'b0000;
   logic [2:0] light_m1, light_m2, light_mT, light_s;
   logic [3:0] grant;
   logic       phase_start;

   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t vecs[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   traffic_phase_scheduler #(
      .MIN_GREEN(4), .MAX_GREEN(10), .YELLOW_T(2), .ALLRED_T(1), .PED_T(15), .CNT_W(8)
   ) dut (
      .clk(clk), .reset(reset), .req(req),
      .light_m1(light_m1), .light_m2(light_m2), .light_mT(light_mT), .light_s(light_s),
      .grant(grant), .phase_start(phase_start)
   );

   task automatic add(input int n, input logic rst, input logic [3:0] rq,
                      input logic [11:0] l, input logic [3:0] g, input logic p);
      vec_t v;
      v.rst = rst; v.req = rq; v.lights = l; v.grant = g; v.ps = p;
      repeat (n) vecs.push_back(v);
   endtask

   task automatic cmp(input string name, input int idx, input logic [11:0] act, input logic [11:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   task automatic check_excl(input int idx);
      int lit;
      lit = int'(light_m1 != R) + int'(light_m2 != R) + int'(light_mT != R) + int'(light_s != R);
      cmp("exclusive", idx, {11'b0, (lit <= 1) && $onehot0(grant)}, 12'h001);
   endtask

   initial begin
      vec_t e;
      int   found;
      int   n_green;
      int   n_gap;

      // Reset then idle: all red, no grants.
      add(3,  1'b1, 4'b0000, ALLR, 4'b0000, 1'b0);
      add(20, 1'b0, 4'b0000, ALLR, 4'b0000, 1'b0);
      // m1 pulse, then side competitor: 4 green, 2 yellow, 1 all-red, side green.
      add(1, 1'b0, 4'b0001, M1G,  4'b0001, 1'b1);
      add(1, 1'b0, 4'b1000, M1G,  4'b0001, 1'b0);
      add(2, 1'b0, 4'b0000, M1G,  4'b0001, 1'b0);
      add(2, 1'b0, 4'b0000, M1Y,  4'b0001, 1'b0);
      add(1, 1'b0, 4'b0000, ALLR, 4'b0000, 1'b0);
      add(1, 1'b0, 4'b0000, SG,   4'b1000, 1'b1);
      add(3, 1'b0, 4'b0000, SG,   4'b1000, 1'b0);
      // Side yields to m1 held high; m1 runs to max green with m2 competing.
      add(1, 1'b0, 4'b0001, SG,   4'b1000, 1'b0);
      add(2, 1'b0, 4'b0001, SY,   4'b1000, 1'b0);
      add(1, 1'b0, 4'b0001, ALLR, 4'b0000, 1'b0);
      add(1, 1'b0, 4'b0001, M1G,  4'b0001, 1'b1);
      add(1, 1'b0, 4'b0011, M1G,  4'b0001, 1'b0);
      add(8, 1'b0, 4'b0001, M1G,  4'b0001, 1'b0);
      add(1, 1'b0, 4'b1100, M1Y,  4'b0001, 1'b0);
      add(1, 1'b0, 4'b0000, M1Y,  4'b0001, 1'b0);
      add(1, 1'b0, 4'b0000, ALLR, 4'b0000, 1'b0);
      // pending=1110 with rr_ptr=0: m2, mT, s in order.
      add(1, 1'b0, 4'b0000, M2G,  4'b0010, 1'b1);
      add(3, 1'b0, 4'b0000, M2G,  4'b0010, 1'b0);
      add(2, 1'b0, 4'b0000, M2Y,  4'b0010, 1'b0);
      add(1, 1'b0, 4'b0000, ALLR, 4'b0000, 1'b0);
      add(1, 1'b0, 4'b0000, TG,   4'b0100, 1'b1);
      add(3, 1'b0, 4'b0000, TG,   4'b0100, 1'b0);
      add(2, 1'b0, 4'b0000, TY,   4'b0100, 1'b0);
      add(1, 1'b0, 4'b0000, ALLR, 4'b0000, 1'b0);
      add(1, 1'b0, 4'b0000, SG,   4'b1000, 1'b1);
      add(3, 1'b0, 4'b0000, SG,   4'b1000, 1'b0);
      // Reset mid-yellow: straight to red, and the m1 demand is forgotten.
      add(1, 1'b0, 4'b0001, SG,   4'b1000, 1'b0);
      add(1, 1'b0, 4'b0000, SY,   4'b1000, 1'b0);
      add(1, 1'b1, 4'b0000, ALLR, 4'b0000, 1'b0);
      add(3, 1'b0, 4'b0000, ALLR, 4'b0000, 1'b0);
      // All four at once after reset: rr_ptr=3 picks m1.
      add(1, 1'b0, 4'b1111, M1G,  4'b0001, 1'b1);
      add(1, 1'b0, 4'b0000, M1G,  4'b0001, 1'b0);

      foreach (vecs[i]) begin
         reset = vecs[i].rst;
         req   = vecs[i].req;
         sb.push_back(vecs[i]);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         cmp("lights", i, {light_s, light_mT, light_m2, light_m1}, e.lights);
         cmp("grant", i, {8'b0, grant}, {8'b0, e.grant});
         cmp("phase_start", i, {11'b0, phase_start}, {11'b0, e.ps});
         check_excl(i);
      end

      // Hand sequence: measure green length and clearance gap directly.
      reset = 1'b1; req = 4'b0000;
      @(posedge clk); #1;
      reset = 1'b0; req = 4'b0011;
      found = 0;
      for (int c = 0; c < 10 && found == 0; c++) begin
         @(posedge clk); #1;
         found = int'(phase_start);
      end
      n_cmp++;
      if (found == 0) begin
         n_bad++;
         $display("FAIL first_grant_wait: no phase_start within 10 cycles, expected 1");
      end
      cmp("first_grant", 1000, {8'b0, grant}, 12'h001);
      req = 4'b0000;
      n_green = 0;
      for (int c = 0; c < 30 && light_m1 == G; c++) begin
         n_green++;
         check_excl(1001);
         @(posedge clk); #1;
      end
      cmp("green_len", 1002, 12'(n_green), 12'd4);
      n_gap = 0;
      for (int c = 0; c < 30 && !phase_start; c++) begin
         n_gap++;
         check_excl(1003);
         @(posedge clk); #1;
      end
      cmp("clear_gap", 1004, 12'(n_gap), 12'd3);
      cmp("next_grant", 1005, {8'b0, grant}, 12'h002);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
